// File: rtl/mips_mc_control.sv
// Multicycle MIPS main-control FSM with run/single-step advance qualification,
// illegal-opcode halt and a retired-instruction counter.
module mips_mc_control #(
   parameter int CNT_W           = 16,
   parameter int HALT_ON_ILLEGAL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_mode,
   input  logic             step,
   input  logic [5:0]       op,
   output logic [3:0]       state,
   output logic             iord,
   output logic             alusrca,
   output logic             regdst,
   output logic             memtoreg,
   output logic [1:0]       alusrcb,
   output logic [1:0]       aluop,
   output logic [1:0]       pcsrc,
   output logic             irwrite,
   output logic             pcwrite,
   output logic             regwrite,
   output logic             memwrite,
   output logic             branch,
   output logic             branch_ne,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BEQ    = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_BNE    = 4'd12,
      S_HALT   = 4'd13
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_t cur_state;
   state_t nxt_state;
   logic   step_q;
   logic   step_rise;
   logic   adv;
   logic   en_ok;
   logic   retire;

   assign step_rise = step & ~step_q;
   assign adv       = run_mode | step_rise;
   // Enables are suppressed during the reset cycle even when running.
   assign en_ok     = adv & ~rst;
   assign state     = cur_state;
   assign halted    = (cur_state == S_HALT);

   // Step edge detector; resets high so a button held through reset is ignored.
   always_ff @(posedge clk) begin
      if (rst) step_q <= 1'b1;
      else     step_q <= step;
   end

   // State register, advancing only on a qualified clock.
   always_ff @(posedge clk) begin
      if (rst)      cur_state <= S_FETCH;
      else if (adv) cur_state <= nxt_state;
   end

   // Retired-instruction counter; wraps naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (rst)                instr_count <= '0;
      else if (adv && retire) instr_count <= instr_count + CNT_W'(1);
   end

   // Next-state decode; retire marks a return to FETCH that completes an instruction.
   always_comb begin
      nxt_state = cur_state;
      retire    = 1'b0;
      case (cur_state)
         S_FETCH:  nxt_state = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: nxt_state = S_MEMADR;
               OP_RTYP:      nxt_state = S_EXEC;
               OP_BEQ:       nxt_state = S_BEQ;
               OP_BNE:       nxt_state = S_BNE;
               OP_ADDI:      nxt_state = S_ADDIEX;
               OP_J:         nxt_state = S_JUMP;
               default: begin
                  if (HALT_ON_ILLEGAL != 0) begin
                     nxt_state = S_HALT;
                  end else begin
                     nxt_state = S_FETCH;
                     retire    = 1'b1;
                  end
               end
            endcase
         end
         S_MEMADR: nxt_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  nxt_state = S_MEMWB;
         S_EXEC:   nxt_state = S_ALUWB;
         S_ADDIEX: nxt_state = S_ADDIWB;
         S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BEQ, S_BNE, S_JUMP: begin
            nxt_state = S_FETCH;
            retire    = 1'b1;
         end
         S_HALT:   nxt_state = S_HALT;
         default:  nxt_state = S_FETCH;
      endcase
   end

   // Datapath selects from state; write enables additionally gated by en_ok.
   always_comb begin
      iord      = 1'b0;
      alusrca   = 1'b0;
      regdst    = 1'b0;
      memtoreg  = 1'b0;
      alusrcb   = 2'b00;
      aluop     = 2'b00;
      pcsrc     = 2'b00;
      irwrite   = 1'b0;
      pcwrite   = 1'b0;
      regwrite  = 1'b0;
      memwrite  = 1'b0;
      branch    = 1'b0;
      branch_ne = 1'b0;
      case (cur_state)
         S_FETCH: begin
            alusrcb = 2'b01;
            irwrite = en_ok;
            pcwrite = en_ok;
         end
         S_DECODE: alusrcb = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = en_ok;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = en_ok;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = en_ok;
         end
         S_ADDIWB: regwrite = en_ok;
         S_BEQ: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = en_ok;
         end
         S_BNE: begin
            alusrca   = 1'b1;
            aluop     = 2'b01;
            pcsrc     = 2'b01;
            branch_ne = en_ok;
         end
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = en_ok;
         end
         // HALT parks the selects at their FETCH values with no enables.
         S_HALT: alusrcb = 2'b01;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed self-checking bench for mips_mc_control: main instance plus
// illegal-as-NOP and narrow-counter variants sharing the same stimulus.
module tb_mips_mc_control;

   logic       clk = 1'b0;
   logic       rst;
   logic       run_mode;
   logic       step;
   logic [5:0] op;

   // main instance (defaults)
   logic [3:0]  state;
   logic        iord, alusrca, regdst, memtoreg;
   logic [1:0]  alusrcb, aluop, pcsrc;
   logic        irwrite, pcwrite, regwrite, memwrite, branch, branch_ne, halted;
   logic [15:0] instr_count;

   // illegal-as-NOP instance
   logic [3:0]  n_state;
   logic        n_iord, n_alusrca, n_regdst, n_memtoreg;
   logic [1:0]  n_alusrcb, n_aluop, n_pcsrc;
   logic        n_irwrite, n_pcwrite, n_regwrite, n_memwrite, n_branch, n_branch_ne, n_halted;
   logic [15:0] n_instr_count;

   // 4-bit counter instance
   logic [3:0]  w_state;
   logic        w_iord, w_alusrca, w_regdst, w_memtoreg;
   logic [1:0]  w_alusrcb, w_aluop, w_pcsrc;
   logic        w_irwrite, w_pcwrite, w_regwrite, w_memwrite, w_branch, w_branch_ne, w_halted;
   logic [3:0]  w_instr_count;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned rw_pulses, ir_pulses;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ILL  = 6'b111111;

   always #5 clk = ~clk;

   mips_mc_control #(.CNT_W(16), .HALT_ON_ILLEGAL(1)) dut (
      .clk(clk), .rst(rst), .run_mode(run_mode), .step(step), .op(op),
      .state(state), .iord(iord), .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg),
      .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
      .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite), .memwrite(memwrite),
      .branch(branch), .branch_ne(branch_ne), .halted(halted), .instr_count(instr_count));

   mips_mc_control #(.CNT_W(16), .HALT_ON_ILLEGAL(0)) dut_nop (
      .clk(clk), .rst(rst), .run_mode(run_mode), .step(step), .op(op),
      .state(n_state), .iord(n_iord), .alusrca(n_alusrca), .regdst(n_regdst), .memtoreg(n_memtoreg),
      .alusrcb(n_alusrcb), .aluop(n_aluop), .pcsrc(n_pcsrc),
      .irwrite(n_irwrite), .pcwrite(n_pcwrite), .regwrite(n_regwrite), .memwrite(n_memwrite),
      .branch(n_branch), .branch_ne(n_branch_ne), .halted(n_halted), .instr_count(n_instr_count));

   mips_mc_control #(.CNT_W(4), .HALT_ON_ILLEGAL(1)) dut_w4 (
      .clk(clk), .rst(rst), .run_mode(run_mode), .step(step), .op(op),
      .state(w_state), .iord(w_iord), .alusrca(w_alusrca), .regdst(w_regdst), .memtoreg(w_memtoreg),
      .alusrcb(w_alusrcb), .aluop(w_aluop), .pcsrc(w_pcsrc),
      .irwrite(w_irwrite), .pcwrite(w_pcwrite), .regwrite(w_regwrite), .memwrite(w_memwrite),
      .branch(w_branch), .branch_ne(w_branch_ne), .halted(w_halted), .instr_count(w_instr_count));

   function automatic logic [5:0] enables();
      return {irwrite, pcwrite, regwrite, memwrite, branch, branch_ne};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // one step press: high 3 clocks, low 2 clocks, tallying enable samples
   task automatic step_pulse(input logic [3:0] exp_state);
      step = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (regwrite) rw_pulses++;
         if (irwrite)  ir_pulses++;
         tick();
      end
      step = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         if (regwrite) rw_pulses++;
         if (irwrite)  ir_pulses++;
         tick();
      end
      #1 chk("step_state", 32'(state), 32'(exp_state));
   endtask

   initial begin
      // ---- reset, then lw in run mode ----
      rst = 1'b1; run_mode = 1'b1; step = 1'b0; op = OP_LW;
      tick();
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
      chk("rst_en", 32'(enables()), 32'd0);
      rst = 1'b0;
      #1 chk("lw_fetch_en", 32'(enables()), 32'b110000);
      tick(); #1 chk("lw_s1", 32'(state), 32'd1);
      tick(); #1 chk("lw_s2", 32'(state), 32'd2);
      chk("lw_s2_rw", 32'(regwrite), 32'd0);
      tick(); #1 chk("lw_s3", 32'(state), 32'd3);
      chk("lw_s3_iord", 32'(iord), 32'd1);
      tick(); #1 chk("lw_s4", 32'(state), 32'd4);
      chk("lw_wb", 32'({regwrite, memtoreg, regdst}), 32'b110);
      tick(); #1 chk("lw_s0", 32'(state), 32'd0);
      chk("lw_s0_rw", 32'(regwrite), 32'd0);
      chk("lw_count", 32'(instr_count), 32'd1);

      // ---- step mode R-type ----
      rst = 1'b1; run_mode = 1'b0; op = OP_RTYP;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("idle_state", 32'(state), 32'd0);
         chk("idle_en", 32'(enables()), 32'd0);
         tick();
      end
      rw_pulses = 0; ir_pulses = 0;
      step_pulse(4'd1);
      step_pulse(4'd6);
      step_pulse(4'd7);
      step_pulse(4'd0);
      chk("step_rw_pulses", rw_pulses, 32'd1);
      chk("step_ir_pulses", ir_pulses, 32'd1);
      chk("step_count", 32'(instr_count), 32'd1);

      // ---- bne, j, sw, addi in run mode ----
      rst = 1'b1; run_mode = 1'b1; op = OP_BNE;
      tick();
      rst = 1'b0;
      tick(); tick(); #1;
      chk("bne_state", 32'(state), 32'd12);
      chk("bne_br", 32'({branch_ne, branch}), 32'b10);
      chk("bne_pcsrc", 32'(pcsrc), 32'd1);
      chk("bne_aluop", 32'(aluop), 32'd1);
      tick(); op = OP_J;
      #1 chk("j_fetch", 32'(state), 32'd0);
      tick(); tick(); #1;
      chk("j_state", 32'(state), 32'd11);
      chk("j_pcwrite", 32'(pcwrite), 32'd1);
      chk("j_pcsrc", 32'(pcsrc), 32'd2);
      tick(); op = OP_SW;
      tick(); tick(); #1;
      chk("sw_memadr", 32'({state, alusrca, alusrcb}), 32'({4'd2, 1'b1, 2'b10}));
      tick(); #1;
      chk("sw_state", 32'(state), 32'd5);
      chk("sw_en", 32'({memwrite, iord, regwrite}), 32'b110);
      tick(); op = OP_ADDI;
      tick(); tick(); #1 chk("addi_ex", 32'(state), 32'd9);
      tick(); #1;
      chk("addi_wb", 32'(state), 32'd10);
      chk("addi_sel", 32'({regwrite, regdst, memtoreg}), 32'b100);
      tick(); #1 chk("mix_count", 32'(instr_count), 32'd4);

      // ---- illegal opcode ----
      op = OP_ILL;
      tick(); tick(); #1;
      chk("ill_state", 32'(state), 32'd13);
      chk("ill_halted", 32'(halted), 32'd1);
      chk("nop_state", 32'(n_state), 32'd0);
      chk("nop_count", 32'(n_instr_count), 32'd5);
      for (int i = 0; i < 50; i++) begin
         tick(); #1;
         chk("halt_state", 32'(state), 32'd13);
         chk("halt_en", 32'(enables()), 32'd0);
         chk("halt_sel", 32'({alusrca, alusrcb, aluop, pcsrc, iord}), 32'b0_01_00_00_0);
      end
      rst = 1'b1;
      #1 chk("halt_count_pre", 32'(instr_count), 32'd4);
      tick(); #1;
      chk("halt_rst_state", 32'(state), 32'd0);
      chk("halt_rst_count", 32'(instr_count), 32'd0);
      chk("halt_rst_halted", 32'(halted), 32'd0);
      rst = 1'b0;

      // ---- counter wrap on 4-bit instance ----
      op = OP_RTYP;
      repeat (60) tick();
      #1;
      chk("w4_count15", 32'(w_instr_count), 32'd15);
      repeat (4) tick();
      #1;
      chk("w4_wrap", 32'(w_instr_count), 32'd0);
      chk("main_count16", 32'(instr_count), 32'd16);

      // ---- step held through reset, then reset mid-instruction ----
      rst = 1'b1; run_mode = 1'b0; step = 1'b1; op = OP_LW;
      tick();
      rst = 1'b0;
      #1 chk("held_en", 32'(enables()), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick(); #1 chk("held_state", 32'(state), 32'd0);
      end
      step = 1'b0;
      tick();
      step = 1'b1;
      #1 chk("rerise_ir", 32'(irwrite), 32'd1);
      tick(); #1 chk("rerise_state", 32'(state), 32'd1);
      step = 1'b0; run_mode = 1'b1;
      tick(); tick(); #1 chk("mid_memrd", 32'(state), 32'd3);
      rst = 1'b1;
      #1 chk("mid_rst_en", 32'(enables()), 32'd0);
      tick(); #1;
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_fetch_en", 32'(enables()), 32'd0);
      rst = 1'b0;
      #1 chk("post_rst_ir", 32'(irwrite), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Parametrised multicycle MIPS main-control FSM.
- Successor to the fixed control unit: adds addi/bne/j states, run/single-step mode, illegal-opcode halt, retired-instruction counter and write-enable gating for step mode.
- Drives the existing datapath muxes and enables; the ALU decoder consumes aluop.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1, 1 = an unknown opcode enters HALT; 0 = treated as NOP and returns to FETCH.

Ports:
- clk  in  1  system clock (divided core clock).
- rst  in  1  synchronous, active-high reset.
- run_mode  in  1  1 = advance every clock; 0 = advance once per step rising edge.
- step  in  1  debounced step button (level).
- op  in  6  instruction opcode, Instruction[31:26].
- state  out  4  current state code, for LEDs.
- iord, alusrca, regdst, memtoreg  out  1  each; mux selects.
- alusrcb, aluop, pcsrc  out  2  each; mux/ALU selects.
- irwrite, pcwrite, regwrite, memwrite, branch, branch_ne  out  1  each; write enables (gated).
- halted  out  1  FSM is in HALT.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Advance qualifier: adv = run_mode | step_rise.
  - step_rise = step & ~step_q; step_q is a registered copy of step.
  - step_q resets to 1, so a step held through reset causes no advance.
- State register updates only when adv=1; otherwise it holds.
- State codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7.
  - BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12, HALT=13.
  - Codes 14 and 15 are unreachable; if entered, go to FETCH on the next adv.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op:
    - 100011 or 101011 -> MEMADR.
    - 000000 -> EXEC.
    - 000100 -> BEQ; 000101 -> BNE.
    - 001000 -> ADDIEX; 000010 -> JUMP.
    - Any other op -> HALT if HALT_ON_ILLEGAL=1, else FETCH.
  - MEMADR -> MEMRD for op=100011, else MEMWR.
  - MEMRD->MEMWB, EXEC->ALUWB, ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BEQ, BNE, JUMP -> FETCH.
  - HALT is terminal until rst.
- Ungated selects, decoded from state only:
  - FETCH: alusrca=0, alusrcb=01, aluop=00, pcsrc=00, iord=0.
  - DECODE: alusrca=0, alusrcb=11, aluop=00.
  - MEMADR, ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD, MEMWR: iord=1.
  - MEMWB: regdst=0, memtoreg=1.
  - EXEC: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, memtoreg=0.
  - ADDIWB: regdst=0, memtoreg=0.
  - BEQ, BNE: alusrca=1, alusrcb=00, aluop=01, pcsrc=01.
  - JUMP: pcsrc=10.
  - All other selects are 0.
- Gated enables assert only when the state decode matches AND adv=1:
  - FETCH: irwrite, pcwrite.
  - MEMWR: memwrite.
  - MEMWB, ALUWB, ADDIWB: regwrite.
  - BEQ: branch. BNE: branch_ne.
  - JUMP: pcwrite.
- In step mode each enable is therefore a single-cycle pulse per step.
- Latency in advances:
  - lw 5; sw, R-type and addi 4; beq, bne and j 3.
- instr_count increments by 1 on every adv transition into FETCH from a terminal state.
  - Wraps from 2^CNT_W-1 to 0.
  - The DECODE->FETCH illegal-NOP path also counts.
  - Entry into HALT does not count.
- halted = (state==HALT). In HALT all enables are 0 and selects are held at the FETCH values.
- rst (synchronous, takes priority over adv):
  - state=FETCH, instr_count=0, step_q=1.
  - All enables forced to 0 during the reset cycle, even if run_mode=1.
  - A reset mid-instruction abandons the instruction; nothing else is cleared.
- step while run_mode=1 has no additional effect; switching mode mid-instruction takes effect on the next cycle.

Test Plan:
- run_mode=1, op=100011 after rst → states 0,1,2,3,4,0 on consecutive clocks; regwrite high for exactly the MEMWB cycle with memtoreg=1; instr_count=1.
- run_mode=0, op=000000, step held low 20 cycles → state stays 0, no enables asserted; then 4 step pulses (each 3 cycles high) → states 1,6,7,0, with exactly one regwrite pulse one clock wide.
- run_mode=1, op=000101 → state 12 with branch_ne=1, branch=0, pcsrc=01, aluop=01; op=000010 → state 11 with pcwrite=1, pcsrc=10.
- op=111111, HALT_ON_ILLEGAL=1 → state 13, halted=1, all enables 0 for 50 cycles; rst → state 0 with instr_count unchanged up to the reset, then 0. With HALT_ON_ILLEGAL=0 → state returns to 0 and instr_count increments.
- CNT_W=4, run 16 R-type instructions → instr_count goes 15 then wraps to 0.
- step held high across rst deassertion → no advance until step falls and rises again; rst asserted in MEMRD with run_mode=1 → next state 0 with all enables 0 in the reset cycle.
